sdram_mport_arbiter: RTL

- Parametrised multi-channel successor of the single write/single read FIFO-to-SDRAM scheduler.
- Sits in the SDRAM controller clock domain, between NCH write FIFOs, NCH read FIFOs and sdram_ctrl.
- Decides which channel gets the next burst and generates per-channel circular (optionally ping-pong) addresses.
- Demultiplexes controller acks to the owning FIFO.

---
 rtl/sdram_mport_pkg.sv | 41 ++++
 rtl/sdram_addr_gen.sv | 51 +++++
 rtl/sdram_mport_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/sdram_mport_pkg.sv
// Shared types and helpers for the multi-channel FIFO-to-SDRAM burst arbiter.
// Slot numbering: write slots 0..NCH-1, read slots NCH..2*NCH-1.
package sdram_mport_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_DATA,
        ST_RD_REQ,
        ST_RD_DATA
    } state_t;

    // Wide enough for any AW+1 span plus twice a burst without overflow
    localparam int OFS_W = 33;

    function automatic logic slot_is_read(input int slot, input int nch);
        return slot >= nch;
    endfunction

    function automatic int slot_channel(input int slot, input int nch);
        return (slot >= nch) ? slot - nch : slot;
    endfunction

    function automatic int slot_after(input int slot, input int nch);
        return (slot + 1) % (2 * nch);
    endfunction

    // Wrap when the burst after the one just finished would not fit in the region
    function automatic logic offset_wraps(input logic [OFS_W-1:0] offset,
                                          input logic [OFS_W-1:0] blen,
                                          input logic [OFS_W-1:0] span);
        return (offset + (blen << 1)) > span;
    endfunction

    function automatic logic [OFS_W-1:0] next_offset(input logic [OFS_W-1:0] offset,
                                                     input logic [OFS_W-1:0] blen,
                                                     input logic [OFS_W-1:0] span);
        return offset_wraps(offset, blen, span) ? '0 : offset + blen;
    endfunction

endpackage

// File: rtl/sdram_addr_gen.sv
// Per-slot circular address generator with optional ping-pong buffer select.
// A read generator follows its write partner: on wrap it lands on the last completed buffer.
module sdram_addr_gen
    import sdram_mport_pkg::*;
#(
    parameter int AW      = 24,
    parameter int LW      = 10,
    parameter int PP_BIT  = 22,
    parameter bit IS_READ = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr_min,
    input  logic [AW-1:0] addr_max,
    input  logic [LW-1:0] burst_len,
    input  logic          burst_done,
    input  logic          pp_en,
    input  logic          partner_buf,
    output logic          pp_buf,
    output logic [AW-1:0] addr
);

    localparam int SPW = AW + 1;

    logic [AW-1:0]  offset;
    logic [SPW-1:0] span;
    logic           wrap;
    logic [OFS_W-1:0] offset_nx;

    assign span      = {1'b0, addr_max} - {1'b0, addr_min} + SPW'(1);
    assign wrap      = offset_wraps(OFS_W'(offset), OFS_W'(burst_len), OFS_W'(span));
    assign offset_nx = next_offset(OFS_W'(offset), OFS_W'(burst_len), OFS_W'(span));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            offset <= '0;
            pp_buf <= IS_READ;
        end else if (burst_done) begin
            offset <= AW'(offset_nx);
            if (wrap && pp_en)
                pp_buf <= IS_READ ? ~partner_buf : ~pp_buf;
        end
    end

    always_comb begin
        addr = addr_min + offset;
        if (pp_en)
            addr[PP_BIT] = pp_buf;
    end

endmodule

// File: rtl/sdram_mport_arbiter.sv
// Round-robin burst arbiter between NCH write FIFOs, NCH read FIFOs and sdram_ctrl.
// Issues one burst at a time and routes controller acks back to the owning FIFO.
module sdram_mport_arbiter
    import sdram_mport_pkg::*;
#(
    parameter int NCH        = 2,
    parameter int AW         = 24,
    parameter int CW         = 10,
    parameter int LW         = 10,
    parameter int FIFO_DEPTH = 1024,
    parameter int PP_BIT     = 22
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     init_done,
    input  logic [LW-1:0]            br_length,
    input  logic [NCH-1:0]           ping_pong_en,
    input  logic [NCH*AW-1:0]        wr_addr_min,
    input  logic [NCH*AW-1:0]        wr_addr_max,
    input  logic [NCH*AW-1:0]        rd_addr_min,
    input  logic [NCH*AW-1:0]        rd_addr_max,
    input  logic [NCH*CW-1:0]        wr_fill,
    input  logic [NCH*CW-1:0]        rd_fill,
    input  logic [NCH-1:0]           rd_valid,
    input  logic                     wr_ack,
    input  logic                     rd_ack,
    output logic                     wr_req,
    output logic                     rd_req,
    output logic [AW-1:0]            sys_wr_addr,
    output logic [AW-1:0]            sys_rd_addr,
    output logic [NCH-1:0]           wr_ack_ch,
    output logic [NCH-1:0]           rd_ack_ch,
    output logic [$clog2(NCH)-1:0]   grant_ch,
    output logic                     busy,
    output logic                     err
);

    localparam int NSLOT = 2 * NCH;
    localparam int SW    = $clog2(NSLOT);
    localparam int GW    = $clog2(NCH);

    state_t         state, state_d;
    logic [SW-1:0]  ptr, slot_q, win_slot;
    logic [GW-1:0]  win_ch;
    logic [LW-1:0]  bl_q, beat_cnt, beat_d;
    logic [NSLOT-1:0] elig;
    logic           win_found, grant_fire, done_fire;
    logic           wr_phase, rd_phase, err_set;
    logic [NCH-1:0] wr_pp_buf, rd_pp_buf, wr_done, rd_done;
    logic [AW-1:0]  wr_gen_addr [NCH];
    logic [AW-1:0]  rd_gen_addr [NCH];

    always_comb begin
        elig = '0;
        for (int i = 0; i < NCH; i++) begin
            elig[i] = (br_length != '0) &&
                      (32'(wr_fill[i*CW +: CW]) >= 32'(br_length));
            elig[NCH+i] = (br_length != '0) && rd_valid[i] &&
                          (32'(rd_fill[i*CW +: CW]) + 32'(br_length) <= 32'(FIFO_DEPTH));
        end
    end

    // First eligible slot at or after the round-robin pointer
    always_comb begin
        win_found = 1'b0;
        win_slot  = '0;
        for (int k = 0; k < NSLOT; k++) begin
            if (!win_found && elig[(int'(ptr) + k) % NSLOT]) begin
                win_found = 1'b1;
                win_slot  = SW'((int'(ptr) + k) % NSLOT);
            end
        end
        win_ch = GW'(slot_channel(int'(win_slot), NCH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d    = state;
        beat_d     = beat_cnt;
        grant_fire = 1'b0;
        done_fire  = 1'b0;
        wr_req     = 1'b0;
        rd_req     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (init_done && win_found) begin
                    grant_fire = 1'b1;
                    state_d    = slot_is_read(int'(win_slot), NCH) ? ST_RD_REQ : ST_WR_REQ;
                end
            end
            ST_WR_REQ: begin
                wr_req = 1'b1;
                if (wr_ack) begin
                    if (bl_q == LW'(1)) begin
                        done_fire = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        beat_d  = LW'(1);
                        state_d = ST_WR_DATA;
                    end
                end
            end
            ST_WR_DATA: begin
                if (wr_ack) begin
                    beat_d = beat_cnt + LW'(1);
                    if (beat_cnt + LW'(1) == bl_q) begin
                        done_fire = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_RD_REQ: begin
                rd_req = 1'b1;
                if (rd_ack) begin
                    if (bl_q == LW'(1)) begin
                        done_fire = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        beat_d  = LW'(1);
                        state_d = ST_RD_DATA;
                    end
                end
            end
            ST_RD_DATA: begin
                if (rd_ack) begin
                    beat_d = beat_cnt + LW'(1);
                    if (beat_cnt + LW'(1) == bl_q) begin
                        done_fire = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign wr_phase = (state == ST_WR_REQ) || (state == ST_WR_DATA);
    assign rd_phase = (state == ST_RD_REQ) || (state == ST_RD_DATA);
    assign busy     = (state != ST_IDLE);
    assign err_set  = (wr_ack && !wr_phase) || (rd_ack && !rd_phase);

    // Misdirected acks are flagged and deliberately not routed to any FIFO
    always_comb begin
        wr_ack_ch = '0;
        rd_ack_ch = '0;
        if (wr_phase && wr_ack) wr_ack_ch[grant_ch] = 1'b1;
        if (rd_phase && rd_ack) rd_ack_ch[grant_ch] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr         <= '0;
            slot_q      <= '0;
            bl_q        <= '0;
            beat_cnt    <= '0;
            grant_ch    <= '0;
            sys_wr_addr <= '0;
            sys_rd_addr <= '0;
            err         <= 1'b0;
        end else begin
            beat_cnt <= beat_d;
            if (grant_fire) begin
                slot_q   <= win_slot;
                bl_q     <= br_length;
                grant_ch <= win_ch;
                if (slot_is_read(int'(win_slot), NCH))
                    sys_rd_addr <= rd_gen_addr[win_ch];
                else
                    sys_wr_addr <= wr_gen_addr[win_ch];
            end
            if (done_fire)
                ptr <= SW'(slot_after(int'(slot_q), NCH));
            if (err_set)
                err <= 1'b1;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign wr_done[i] = done_fire && (slot_q == SW'(i));
        assign rd_done[i] = done_fire && (slot_q == SW'(NCH + i));

        sdram_addr_gen #(.AW(AW), .LW(LW), .PP_BIT(PP_BIT), .IS_READ(1'b0)) u_wr_gen (
            .clk         (clk),
            .rst         (rst),
            .addr_min    (wr_addr_min[i*AW +: AW]),
            .addr_max    (wr_addr_max[i*AW +: AW]),
            .burst_len   (bl_q),
            .burst_done  (wr_done[i]),
            .pp_en       (ping_pong_en[i]),
            .partner_buf (rd_pp_buf[i]),
            .pp_buf      (wr_pp_buf[i]),
            .addr        (wr_gen_addr[i])
        );

        sdram_addr_gen #(.AW(AW), .LW(LW), .PP_BIT(PP_BIT), .IS_READ(1'b1)) u_rd_gen (
            .clk         (clk),
            .rst         (rst),
            .addr_min    (rd_addr_min[i*AW +: AW]),
            .addr_max    (rd_addr_max[i*AW +: AW]),
            .burst_len   (bl_q),
            .burst_done  (rd_done[i]),
            .pp_en       (ping_pong_en[i]),
            .partner_buf (wr_pp_buf[i]),
            .pp_buf      (rd_pp_buf[i]),
            .addr        (rd_gen_addr[i])
        );
    end

endmodule
